fetch_sequencer: RTL

Control block that drives the fetch stage's pc_write / pc_write_back_value / clear_instruction inputs and a PC-freeze line. It sequences boot, branch redirects, load-use stalls, interrupt entry (drain, save PC, vector) and return (wait for popped PC, redirect). It sits between the hazard/branch logic in decode/execute and the fetch stage, and is the only source of PC redirects.

---
 rtl/fetch_seq_if.sv | 34 +++
 rtl/fetch_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_if.sv
// Signal bundle between the fetch sequencer and the fetch / hazard / interrupt logic around it.
// The sequencer takes the master modport; the pipeline side takes the slave modport.
interface fetch_seq_if;
  logic [15:0] pc_current;
  logic        stall_req;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        int_req;
  logic        ret_req;
  logic        ret_pc_valid;
  logic [15:0] ret_pc;
  logic        pc_write;
  logic [15:0] pc_write_back_value;
  logic        clear_instruction;
  logic        pc_hold;
  logic        int_save_valid;
  logic [15:0] int_save_pc;
  logic        int_ack;
  logic        in_isr;

  modport master (
    input  pc_current, stall_req, branch_taken, branch_target,
           int_req, ret_req, ret_pc_valid, ret_pc,
    output pc_write, pc_write_back_value, clear_instruction, pc_hold,
           int_save_valid, int_save_pc, int_ack, in_isr
  );

  modport slave (
    output pc_current, stall_req, branch_taken, branch_target,
           int_req, ret_req, ret_pc_valid, ret_pc,
    input  pc_write, pc_write_back_value, clear_instruction, pc_hold,
           int_save_valid, int_save_pc, int_ack, in_isr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Sole source of PC redirects: sequences boot, branch redirects, load-use stalls,
// interrupt entry (drain, save PC, vector) and interrupt return.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h0020,
  parameter logic [15:0] INT_PC       = 16'h0010,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  fetch_seq_if.master     bus,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    RUN       = 3'd1,
    FLUSH     = 3'd2,
    INT_DRAIN = 3'd3,
    INT_SAVE  = 3'd4,
    RET_WAIT  = 3'd5
  } state_e;

  // The state after a redirect cycle; the redirect cycle itself is the first NOP cycle.
  localparam state_e     REDIR_NEXT   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_e     DRAIN_FIRST  = (DRAIN_CYCLES > 1) ? INT_DRAIN : INT_SAVE;
  localparam logic [2:0] DRAIN_RELOAD = 3'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] saved_pc_q, saved_pc_d;
  logic        in_isr_q, in_isr_d;
  logic        pc_write_q, pc_write_d;
  logic [15:0] value_q, value_d;
  logic        clear_q, clear_d;
  logic        hold_q, hold_d;
  logic        save_valid_q, save_valid_d;
  logic [15:0] save_pc_q, save_pc_d;
  logic        ack_q, ack_d;

  // Every control output is a register: decisions made at an edge become visible in the
  // following cycle, and the fetch stage acts on them at the edge that ends that cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT;
      cnt_q        <= 3'd0;
      saved_pc_q   <= 16'h0000;
      in_isr_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      value_q      <= 16'h0000;
      clear_q      <= 1'b0;
      hold_q       <= 1'b0;
      save_valid_q <= 1'b0;
      save_pc_q    <= 16'h0000;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      saved_pc_q   <= saved_pc_d;
      in_isr_q     <= in_isr_d;
      pc_write_q   <= pc_write_d;
      value_q      <= value_d;
      clear_q      <= clear_d;
      hold_q       <= hold_d;
      save_valid_q <= save_valid_d;
      save_pc_q    <= save_pc_d;
      ack_q        <= ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    saved_pc_d   = saved_pc_q;
    in_isr_d     = in_isr_q;
    pc_write_d   = 1'b0;
    value_d      = 16'h0000;
    clear_d      = 1'b0;
    hold_d       = 1'b0;
    save_valid_d = 1'b0;
    save_pc_d    = 16'h0000;
    ack_d        = 1'b0;

    case (state_q)
      BOOT: begin
        pc_write_d = 1'b1;
        value_d    = RESET_PC;
        clear_d    = 1'b1;
        state_d    = REDIR_NEXT;
        cnt_d      = FLUSH_RELOAD;
      end

      RUN: begin
        if (bus.branch_taken) begin
          pc_write_d = 1'b1;
          value_d    = bus.branch_target;
          clear_d    = 1'b1;
          state_d    = REDIR_NEXT;
          cnt_d      = FLUSH_RELOAD;
        end else if (bus.ret_req) begin
          hold_d  = 1'b1;
          clear_d = 1'b1;
          state_d = RET_WAIT;
        end else if (bus.int_req && !in_isr_q) begin
          saved_pc_d = bus.pc_current;
          hold_d     = 1'b1;
          clear_d    = 1'b1;
          state_d    = DRAIN_FIRST;
          cnt_d      = DRAIN_RELOAD;
        end else if (bus.stall_req) begin
          hold_d  = 1'b1;
          clear_d = 1'b1;
        end
      end

      FLUSH: begin
        clear_d = 1'b1;
        if (bus.branch_taken) begin
          pc_write_d = 1'b1;
          value_d    = bus.branch_target;
          state_d    = REDIR_NEXT;
          cnt_d      = FLUSH_RELOAD;
        end else if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      // A branch resolving while draining is the true continuation point, so it becomes
      // the saved PC instead of redirecting fetch.
      INT_DRAIN, INT_SAVE: begin
        if (bus.branch_taken) begin
          saved_pc_d = bus.branch_target;
          hold_d     = 1'b1;
          clear_d    = 1'b1;
          state_d    = DRAIN_FIRST;
          cnt_d      = DRAIN_RELOAD;
        end else if (state_q == INT_DRAIN) begin
          hold_d  = 1'b1;
          clear_d = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = INT_SAVE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else begin
          save_valid_d = 1'b1;
          save_pc_d    = saved_pc_q;
          pc_write_d   = 1'b1;
          value_d      = INT_PC;
          clear_d      = 1'b1;
          ack_d        = 1'b1;
          in_isr_d     = 1'b1;
          state_d      = REDIR_NEXT;
          cnt_d        = FLUSH_RELOAD;
        end
      end

      RET_WAIT: begin
        clear_d = 1'b1;
        if (bus.ret_pc_valid) begin
          pc_write_d = 1'b1;
          value_d    = bus.ret_pc;
          in_isr_d   = 1'b0;
          state_d    = REDIR_NEXT;
          cnt_d      = FLUSH_RELOAD;
        end else begin
          hold_d = 1'b1;
        end
      end

      default: begin
        state_d = BOOT;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign bus.pc_write            = pc_write_q;
  assign bus.pc_write_back_value = value_q;
  assign bus.clear_instruction   = clear_q;
  assign bus.pc_hold             = hold_q;
  assign bus.int_save_valid      = save_valid_q;
  assign bus.int_save_pc         = save_pc_q;
  assign bus.int_ack             = ack_q;
  assign bus.in_isr              = in_isr_q;
  assign dbg_state_o             = state_q;

endmodule
